// File: rtl/poly_ma_stream.sv
// Streaming modular adder o = (a + b) mod q over N coefficients.
// Two-stage valid/ready pipeline with backpressure, last tag and done pulse.
module poly_ma_stream #(
  parameter int unsigned N = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] q,
  input  logic [4:0]  q_width,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] a,
  input  logic [23:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] o,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state;
  logic [CW-1:0] in_cnt;
  logic [CW-1:0] out_cnt;
  logic [23:0]   q_reg;
  logic [4:0]    qw_reg;

  logic          s1_valid;
  logic          s1_last;
  logic [23:0]   s1_sum;
  logic [24:0]   s1_diff;

  logic          s1_adv;
  logic          s2_adv;
  logic          in_fire;
  logic          out_fire;
  logic          in_last;
  logic          final_fire;
  logic [24:0]   sum_next;
  logic [24:0]   diff_next;

  assign s2_adv     = !out_valid | out_ready;
  assign s1_adv     = !s1_valid | s2_adv;
  assign in_ready   = (state == RUN) & (in_cnt < CW'(N)) & s1_adv;
  assign in_fire    = in_valid & in_ready;
  assign out_fire   = out_valid & out_ready;
  assign in_last    = (in_cnt == CW'(N - 1));
  assign final_fire = (state == DRAIN) & out_fire & (out_cnt == CW'(N - 1));

  assign sum_next  = {1'b0, a} + {1'b0, b};
  assign diff_next = sum_next - {1'b0, q_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      in_cnt  <= '0;
      out_cnt <= '0;
      q_reg   <= '0;
      qw_reg  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (out_fire) out_cnt <= out_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            q_reg   <= q;
            qw_reg  <= q_width;
            in_cnt  <= '0;
            out_cnt <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (in_fire) begin
            in_cnt <= in_cnt + 1'b1;
            if (in_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (final_fire) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_sum    <= '0;
      s1_diff   <= '0;
      out_valid <= 1'b0;
      o         <= '0;
      out_last  <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_fire;
        if (in_fire) begin
          s1_sum  <= sum_next[23:0];
          s1_diff <= diff_next;
          s1_last <= in_last;
        end
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        out_last  <= s1_valid & s1_last;
        // |diff| < 2^q_width, so bit q_width of diff is its sign
        if (s1_valid) o <= s1_diff[qw_reg] ? s1_sum : s1_diff[23:0];
      end
    end
  end

endmodule

// File: tb/tb_poly_ma_stream.sv
// Self-checking bench for poly_ma_stream: directed table, exhaustive mod-17
// pairs, throughput, backpressure, ignored start and mid-run reset.
module tb_poly_ma_stream;
  localparam int N = 256;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [23:0] q;
  logic [4:0]  q_width;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] a;
  logic [23:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] o;
  logic        out_last;
  logic        busy;
  logic        done;

  poly_ma_stream #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .q(q), .q_width(q_width),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .o(o), .out_last(out_last),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic [23:0] exp_o;
  } vec_t;

  typedef struct {
    logic [23:0] o;
    logic        last;
  } sb_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [23:0] a_arr [N];
  logic [23:0] b_arr [N];
  logic [23:0] exp_arr [N];
  sb_t         sbq [$];

  bit mon_en = 0;
  bit tb_run = 0;
  int tb_in_cnt = 0;
  int tb_out_cnt = 0;
  int occ = 0;
  int done_cnt = 0;
  int first_in_cyc = 0;
  int last_out_cyc = 0;
  int rdy_mode = 0;
  bit gap_mode = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Scoreboard and protocol monitor, sampled on the falling edge.
  initial begin
    bit          prev_stall;
    logic [23:0] prev_o;
    logic        prev_last;
    bit          in_f;
    bit          out_f;
    sb_t         e;
    prev_stall = 0;
    prev_o     = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!mon_en) begin
        prev_stall = 0;
      end else begin
        in_f  = in_valid & in_ready;
        out_f = out_valid & out_ready;
        chk("in_ready", int'(in_ready),
            int'(tb_run && tb_in_cnt < N && !(occ == 2 && !out_ready)));
        if (prev_stall) begin
          chk("stall_valid", int'(out_valid), 1);
          chk("stall_o", int'(o), int'(prev_o));
          chk("stall_last", int'(out_last), int'(prev_last));
        end
        if (out_f) begin
          if (sbq.size() == 0) begin
            chk("spurious_output", tb_out_cnt, -1);
          end else begin
            e = sbq.pop_front();
            chk("o", int'(o), int'(e.o));
            chk("out_last", int'(out_last), int'(e.last));
          end
          tb_out_cnt++;
          last_out_cyc = cyc;
        end
        if (in_f) begin
          if (tb_in_cnt >= N) begin
            chk("extra_input", tb_in_cnt, N - 1);
          end else begin
            e.o    = exp_arr[tb_in_cnt];
            e.last = (tb_in_cnt == N - 1);
            sbq.push_back(e);
            if (tb_in_cnt == 0) first_in_cyc = cyc;
            tb_in_cnt++;
            if (tb_in_cnt == N) tb_run = 0;
          end
        end
        occ = occ + int'(in_f) - int'(out_f);
        if (done) begin
          done_cnt++;
          chk("done_out_cnt", tb_out_cnt, N);
          chk("done_timing", last_out_cyc, cyc - 1);
          chk("done_busy", int'(busy), 0);
        end
        prev_stall = out_valid & !out_ready;
        prev_o     = o;
        prev_last  = out_last;
      end
    end
  end

  // out_ready driver: 0 = always high, 1 = random 50%, 2 = held low
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] mod_add(logic [23:0] x, logic [23:0] y, logic [23:0] m);
    return 24'((int'(x) + int'(y)) % int'(m));
  endfunction

  task automatic do_start(input logic [23:0] qv, input logic [4:0] qwv);
    @(posedge clk); #1;
    start = 1'b1; q = qv; q_width = qwv;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_rise", int'(busy), 1);
    tb_in_cnt  = 0;
    tb_out_cnt = 0;
    tb_run     = 1;
  endtask

  task automatic feed(input int n);
    int i;
    int budget;
    i = 0;
    budget = 0;
    while (i < n) begin
      @(posedge clk); #1;
      budget++;
      if (budget > 20000) begin
        chk("feed_timeout", i, n);
        break;
      end
      if (gap_mode && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        a = a_arr[i];
        b = b_arr[i];
        @(negedge clk);
        if (in_ready) i++;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int budget;
    budget = 0;
    while (done_cnt == d0 && budget < 5000) begin
      @(posedge clk);
      budget++;
    end
    if (done_cnt == d0) chk("done_timeout", done_cnt, d0 + 1);
    repeat (3) @(negedge clk);
    chk("single_done", done_cnt, d0 + 1);
    chk("out_count", tb_out_cnt, N);
    chk("busy_after_done", int'(busy), 0);
  endtask

  task automatic run(input logic [23:0] qv, input logic [4:0] qwv);
    int d0;
    d0 = done_cnt;
    do_start(qv, qwv);
    feed(N);
    wait_done(d0);
  endtask

  task automatic fill_pairs17(input int base);
    int k;
    for (int i = 0; i < N; i++) begin
      k = (base + i) % 289;
      a_arr[i]   = 24'(k / 17);
      b_arr[i]   = 24'(k % 17);
      exp_arr[i] = mod_add(a_arr[i], b_arr[i], 24'd17);
    end
  endtask

  initial begin
    vec_t tbl [8];
    int   d0;

    tbl[0] = '{24'd8380416, 24'd1,       24'd0};
    tbl[1] = '{24'd5,       24'd7,       24'd12};
    tbl[2] = '{24'd8380416, 24'd8380416, 24'd8380415};
    tbl[3] = '{24'd0,       24'd0,       24'd0};
    tbl[4] = '{24'd4190208, 24'd4190209, 24'd0};
    tbl[5] = '{24'd4190208, 24'd4190208, 24'd8380416};
    tbl[6] = '{24'd8380000, 24'd417,     24'd0};
    tbl[7] = '{24'd8380000, 24'd416,     24'd8380416};

    rst_n = 1'b0; start = 1'b0; q = '0; q_width = '0;
    in_valid = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_o", int'(o), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst_n  = 1'b1;
    mon_en = 1;

    // Directed table against q = 8380417
    for (int i = 0; i < N; i++) begin
      a_arr[i]   = tbl[i % 8].a;
      b_arr[i]   = tbl[i % 8].b;
      exp_arr[i] = tbl[i % 8].exp_o;
    end
    rdy_mode = 0; gap_mode = 0;
    run(24'd8380417, 5'd23);

    // All mod-17 pairs, first run at full throughput
    fill_pairs17(0);
    run(24'd17, 5'd5);
    chk("throughput", last_out_cyc - first_in_cyc, N + 1);

    // Remaining pairs with random backpressure and input gaps
    fill_pairs17(256);
    rdy_mode = 1; gap_mode = 1;
    run(24'd17, 5'd5);

    // start pulsed in RUN and DRAIN must be ignored
    fill_pairs17(100);
    rdy_mode = 0; gap_mode = 0;
    d0 = done_cnt;
    do_start(24'd17, 5'd5);
    fork
      feed(N);
      begin
        repeat (40) @(posedge clk);
        #1;
        start = 1'b1; q = 24'd5; q_width = 5'd3;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_run_start", int'(busy), 1);
      end
    join
    rdy_mode = 2; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; q = 24'd5; q_width = 5'd3;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_drain_start", int'(busy), 1);
    rdy_mode = 0;
    wait_done(d0);

    // Reset after 100 accepted inputs
    fill_pairs17(7);
    rdy_mode = 1; gap_mode = 0;
    d0 = done_cnt;
    do_start(24'd17, 5'd5);
    feed(100);
    mon_en = 0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", int'(in_ready), 0);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_o", int'(o), 0);
    chk("mid_rst_out_last", int'(out_last), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    sbq.delete();
    occ = 0; tb_run = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1;
    repeat (4) @(posedge clk);
    chk("no_done_after_reset", done_cnt, d0);
    run(24'd17, 5'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
